int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 133 +++++++++++++
 tb/tb_int_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronized rising-edge sources, single-bit pending latches,
// lowest-index priority, and a memory-mapped MASK/PENDING/EOI/STATE window.
module int_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFF0,
  parameter int          CAUSE_BASE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [31:0]      Addr,
  input  logic             Memread,
  input  logic [1:0]       Memwrite,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rd_hit,
  output logic             INTin,
  output logic [31:0]      INTnum
);

  typedef enum logic {IDLE, SIGNAL} state_t;

  localparam logic [3:0] OFF_MASK    = 4'h0;
  localparam logic [3:0] OFF_PENDING = 4'h4;
  localparam logic [3:0] OFF_EOI     = 4'h8;
  localparam logic [3:0] OFF_STATE   = 4'hC;

  state_t           state, state_next;
  logic [N_IRQ-1:0] sync1, sync2, hist, rise;
  logic [2:0]       arm;
  logic [N_IRQ-1:0] mask, pending, req, grant_oh;
  logic [2:0]       in_service_id, grant_id;
  logic             grant_valid, take;
  logic             win_hit, wr_cond, wr_prev, wr_fire, mask_we, eoi_we;
  logic [3:0]       off;
  logic             unused_ok;

  assign unused_ok = &{1'b0, wdata[31:N_IRQ]};

  // arm holds edge detection off until hist carries a real post-reset sample,
  // so a line already high at reset release is never seen as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
      arm   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source;
      // blocking here would collapse the synchronizer chain into one stage.
      sync1 <= irq;
      sync2 <= sync1;
      hist  <= sync2;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  assign rise = sync2 & ~hist & {N_IRQ{arm[2]}};

  assign win_hit  = (Addr[31:4] == BASE_ADDR[31:4]);
  assign off      = Addr[3:0];
  assign wr_cond  = win_hit && (Memwrite == 2'd1 || Memwrite == 2'd3);
  assign wr_fire  = wr_cond && !wr_prev;
  assign mask_we  = wr_fire && (off == OFF_MASK);
  assign eoi_we   = wr_fire && (off == OFF_EOI);

  assign req      = pending & mask;
  assign grant_oh = req & (-req);

  always_comb begin
    grant_valid = |req;
    grant_id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) grant_id = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = SIGNAL;
          take       = 1'b1;
        end
      end
      SIGNAL: begin
        if (eoi_we && wdata[2:0] == in_service_id) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A rise on the source being granted wins over its clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev       <= 1'b0;
      mask          <= '0;
      pending       <= '0;
      in_service_id <= '0;
    end else begin
      wr_prev <= wr_cond;
      if (mask_we) mask <= wdata[N_IRQ-1:0];
      if (take)    in_service_id <= grant_id;
      pending <= (pending & ~(take ? grant_oh : '0)) | rise;
    end
  end

  assign INTin  = (state == SIGNAL);
  assign INTnum = INTin ? 32'(CAUSE_BASE) + 32'(in_service_id) : 32'd0;
  assign rd_hit = !rst && Memread && win_hit;

  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (off)
        OFF_MASK:    rdata[N_IRQ-1:0] = mask;
        OFF_PENDING: rdata[N_IRQ-1:0] = pending;
        OFF_STATE:   rdata[3:0]       = {INTin, in_service_id};
        default:     rdata            = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: register-access vector table, directed
// interrupt scenarios, and randomized traffic against a sample-history reference model.
module tb_int_ctrl;

  logic        clk, rst;
  logic [7:0]  irq;
  logic [31:0] Addr, wdata;
  logic        Memread;
  logic [1:0]  Memwrite;
  logic [31:0] rdata, INTnum;
  logic        rd_hit, INTin;

  int n_checks = 0;
  int n_err    = 0;

  int_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .Addr(Addr), .Memread(Memread),
    .Memwrite(Memwrite), .wdata(wdata), .rdata(rdata), .rd_hit(rd_hit),
    .INTin(INTin), .INTnum(INTnum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: registers as plain bit vectors, irq history as the last
  // three post-reset samples; a rise between two consecutive samples becomes
  // pending two clock edges after the later one.
  bit [7:0] m_mask, m_pend;
  bit       m_serv, m_wr_prev;
  int       m_id;
  bit [7:0] samp[$];

  function automatic bit in_win(logic [31:0] a);
    return a[31:4] == 28'hFFF;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_serv = 0; m_wr_prev = 0; m_id = 0;
    samp.delete();
  endtask

  task automatic model_step();
    bit cond, fire;
    bit [7:0] rises, req;
    cond = (Memwrite == 2'd1 || Memwrite == 2'd3) && in_win(Addr);
    fire = cond && !m_wr_prev;
    m_wr_prev = cond;
    rises = 0;
    if (samp.size() == 3) rises = samp[1] & ~samp[0];
    samp.push_back(irq);
    if (samp.size() > 3) void'(samp.pop_front());
    req = m_pend & m_mask;
    if (!m_serv) begin
      if (req != 0) begin
        for (int i = 0; i < 8; i++) if (req[i]) begin m_id = i; break; end
        m_pend[m_id] = 1'b0;
        m_serv = 1'b1;
      end
    end else if (fire && Addr[3:0] == 4'h8 && int'(wdata[2:0]) == m_id) begin
      m_serv = 1'b0;
    end
    if (fire && Addr[3:0] == 4'h0) m_mask = wdata[7:0];
    m_pend |= rises;
  endtask

  task automatic model_read(output logic hit, output logic [31:0] data);
    hit = 0; data = 0;
    if (!rst && Memread && in_win(Addr)) begin
      hit = 1;
      case (Addr[3:0])
        4'h0: data = {24'h0, m_mask};
        4'h4: data = {24'h0, m_pend};
        4'hC: data = {28'h0, m_serv, 3'(m_id)};
        default: data = 0;
      endcase
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic bus_idle();
    Memread = 0; Memwrite = 0; Addr = 0; wdata = 0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    Memwrite = 2'd1; Addr = a; wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic rd_check(string name, logic [31:0] a, logic [31:0] exp);
    Memread = 1; Addr = a;
    #1;
    check({name, "_hit"}, 32'(rd_hit), 32'd1);
    check(name, rdata, exp);
    Memread = 0; Addr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    bus_idle();
    tick();
    tick();
    rst = 0;
    repeat (4) tick();
  endtask

  task automatic wait_intin(string name, int max_cycles);
    int k = 0;
    while (!INTin && k < max_cycles) begin
      tick();
      k++;
    end
    check({name, "_timeout"}, 32'(INTin), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [1:0]  mw;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic        e_hit;
    logic [31:0] e_data;

    rst = 1; irq = 0;
    bus_idle();
    #2;
    check("reset_intin", 32'(INTin), 32'd0);
    check("reset_intnum", INTnum, 32'd0);
    check("reset_rd_hit", 32'(rd_hit), 32'd0);
    do_reset();

    // Register-access vectors, one cycle each.
    vecs[0]  = '{32'hFFF0, 1'b1, 2'd0, 32'h0,  1'b1, 32'h0};
    vecs[1]  = '{32'hFFF4, 1'b1, 2'd0, 32'h0,  1'b1, 32'h0};
    vecs[2]  = '{32'hFFFC, 1'b1, 2'd0, 32'h0,  1'b1, 32'h0};
    vecs[3]  = '{32'hFFF1, 1'b1, 2'd0, 32'h0,  1'b1, 32'h0};
    vecs[4]  = '{32'h1000, 1'b1, 2'd0, 32'h0,  1'b0, 32'h0};
    vecs[5]  = '{32'hFFF0, 1'b0, 2'd2, 32'hFF, 1'b0, 32'h0};
    vecs[6]  = '{32'hFFF0, 1'b1, 2'd0, 32'h0,  1'b1, 32'h0};
    vecs[7]  = '{32'hFFF0, 1'b0, 2'd1, 32'h5A, 1'b0, 32'h0};
    vecs[8]  = '{32'hFFF0, 1'b1, 2'd0, 32'h0,  1'b1, 32'h5A};
    vecs[9]  = '{32'hFFF0, 1'b0, 2'd3, 32'h0,  1'b0, 32'h0};
    vecs[10] = '{32'hFFF2, 1'b0, 2'd1, 32'hFF, 1'b0, 32'h0};
    vecs[11] = '{32'hFFF0, 1'b1, 2'd0, 32'h0,  1'b1, 32'h0};
    for (int i = 0; i < 12; i++) begin
      Addr = vecs[i].addr; Memread = vecs[i].rd; Memwrite = vecs[i].mw; wdata = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_hit", i), 32'(rd_hit), 32'(vecs[i].hit));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdat);
      check($sformatf("vec%0d_intin", i), 32'(INTin), 32'd0);
      tick();
    end
    bus_idle();

    // Single enabled source: pending, selection, EOI.
    do_reset();
    wr(32'hFFF0, 32'h04);
    irq = 8'h04; tick(); tick(); irq = 8'h00; tick();
    rd_check("s1_pending_set", 32'hFFF4, 32'h04);
    check("s1_intin_before", 32'(INTin), 32'd0);
    tick();
    check("s1_intin", 32'(INTin), 32'd1);
    check("s1_intnum", INTnum, 32'd18);
    rd_check("s1_pending_clr", 32'hFFF4, 32'h00);
    rd_check("s1_state", 32'hFFFC, 32'h0A);
    Memwrite = 2'd1; Addr = 32'hFFF8; wdata = 32'd2;
    #1;
    check("s1_intin_eoi_cycle", 32'(INTin), 32'd1);
    tick(); bus_idle();
    check("s1_intin_after_eoi", 32'(INTin), 32'd0);

    // Two simultaneous sources: lowest index first.
    do_reset();
    wr(32'hFFF0, 32'hFF);
    irq = 8'h22; tick(); tick(); irq = 8'h00;
    wait_intin("s2_first", 8);
    check("s2_intnum_first", INTnum, 32'd17);
    rd_check("s2_pending_left", 32'hFFF4, 32'h20);
    wr(32'hFFF8, 32'd1);
    check("s2_idle_gap", 32'(INTin), 32'd0);
    check("s2_idle_intnum", INTnum, 32'd0);
    tick();
    check("s2_intin_second", 32'(INTin), 32'd1);
    check("s2_intnum_second", INTnum, 32'd21);
    wr(32'hFFF8, 32'd5);
    check("s2_done", 32'(INTin), 32'd0);

    // Masked source latches pending; unmasking signals it.
    do_reset();
    irq = 8'h08; tick(); tick(); irq = 8'h00;
    repeat (4) tick();
    check("s3_masked_intin", 32'(INTin), 32'd0);
    rd_check("s3_pending", 32'hFFF4, 32'h08);
    wr(32'hFFF0, 32'h08);
    check("s3_write_edge", 32'(INTin), 32'd0);
    tick();
    check("s3_intin", 32'(INTin), 32'd1);
    check("s3_intnum", INTnum, 32'd19);
    wr(32'hFFF8, 32'd3);

    // Wrong-id EOI, held EOI write, re-edge on in-service source.
    do_reset();
    wr(32'hFFF0, 32'hFF);
    irq = 8'h10; tick(); tick(); irq = 8'h00; tick(); tick();
    check("s4_intnum", INTnum, 32'd20);
    wr(32'hFFF8, 32'd6);
    check("s4_wrong_eoi", 32'(INTin), 32'd1);
    irq = 8'h10; tick(); tick();
    Memwrite = 2'd1; Addr = 32'hFFF8; wdata = 32'd4;
    tick();
    check("s4_eoi_idle", 32'(INTin), 32'd0);
    tick();
    check("s4_resignal", 32'(INTin), 32'd1);
    check("s4_resignal_num", INTnum, 32'd20);
    tick();
    check("s4_held_once", 32'(INTin), 32'd1);
    bus_idle(); irq = 8'h00; tick();
    check("s4_still", 32'(INTin), 32'd1);
    wr(32'hFFF8, 32'd4);
    check("s4_done", 32'(INTin), 32'd0);

    // Reset mid-SIGNAL with irq[0] held high through release.
    do_reset();
    wr(32'hFFF0, 32'h01);
    irq = 8'h01;
    wait_intin("s5_enter", 8);
    #2;
    rst = 1;
    model_reset();
    #1;
    check("s5_async_intin", 32'(INTin), 32'd0);
    check("s5_async_intnum", INTnum, 32'd0);
    Memread = 1; Addr = 32'hFFF0;
    #1;
    check("s5_rst_rd_hit", 32'(rd_hit), 32'd0);
    check("s5_rst_rdata", rdata, 32'd0);
    bus_idle();
    tick(); tick();
    rst = 0;
    repeat (8) tick();
    check("s5_no_intin", 32'(INTin), 32'd0);
    rd_check("s5_mask", 32'hFFF0, 32'h00);
    rd_check("s5_pending", 32'hFFF4, 32'h00);
    rd_check("s5_state", 32'hFFFC, 32'h00);
    wr(32'hFFF0, 32'hFF);
    repeat (4) tick();
    check("s5_held_no_edge", 32'(INTin), 32'd0);
    irq = 8'h00;

    // Randomized traffic against the reference model, with one mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      if (c == 1500) do_reset();
      tick();
      check("rnd_intin", 32'(INTin), 32'(m_serv));
      check("rnd_intnum", INTnum, m_serv ? 32'(16 + m_id) : 32'd0);
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      r = $urandom_range(0, 9);
      if (r >= 2) begin
        case ($urandom_range(0, 9))
          6:       Memwrite = 2'd1;
          7:       Memwrite = 2'd3;
          8:       Memwrite = 2'd2;
          default: Memwrite = 2'd0;
        endcase
        case ($urandom_range(0, 5))
          0: Addr = 32'hFFF0;
          1: Addr = 32'hFFF4;
          2: Addr = 32'hFFF8;
          3: Addr = 32'hFFFC;
          4: Addr = 32'hFFF0 | 32'($urandom_range(0, 15));
          default: Addr = $urandom;
        endcase
        wdata = $urandom;
        if ($urandom_range(0, 1) == 1) wdata[2:0] = 3'(m_id);
        Memread = 1'($urandom_range(0, 1));
      end
      #1;
      model_read(e_hit, e_data);
      check("rnd_rd_hit", 32'(rd_hit), 32'(e_hit));
      check("rnd_rdata", rdata, e_data);
    end
    bus_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
